ifu_fetch: RTL and testbench

Instruction fetch unit for the rvseed core. It owns the fetch PC, issues word requests to instruction memory, and buffers returned instructions in a 2-entry queue. It presents them to the IF/ID pipeline register as `ifu2idu_en`/`ifu2idu_pc`/`ifu2idu_inst`. On a branch or jump reported by EXU it redirects the fetch PC, flushes the queue and discards any in-flight response.

---
 rtl/ifu_fetch_if.sv | 29 ++
 rtl/ifu_fetch.sv | 147 ++++++++++++++
 tb/tb_ifu_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch unit bundle: instruction-memory request/response, EXU redirect and IF/ID delivery.
interface ifu_fetch_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 ifu2imem_req;
    logic [CPU_WIDTH-1:0] ifu2imem_addr;
    logic                 imem2ifu_gnt;
    logic                 imem2ifu_rvalid;
    logic [CPU_WIDTH-1:0] imem2ifu_rdata;
    logic                 idu2ifu_stall;
    logic                 exu2ifu_branch_en;
    logic                 exu2ifu_jump_en;
    logic [CPU_WIDTH-1:0] exu2ifu_target_pc;
    logic                 ifu2idu_en;
    logic [CPU_WIDTH-1:0] ifu2idu_pc;
    logic [CPU_WIDTH-1:0] ifu2idu_inst;

    modport master (
        output ifu2imem_req, ifu2imem_addr, ifu2idu_en, ifu2idu_pc, ifu2idu_inst,
        input  imem2ifu_gnt, imem2ifu_rvalid, imem2ifu_rdata, idu2ifu_stall,
               exu2ifu_branch_en, exu2ifu_jump_en, exu2ifu_target_pc
    );

    modport slave (
        input  ifu2imem_req, ifu2imem_addr, ifu2idu_en, ifu2idu_pc, ifu2idu_inst,
        output imem2ifu_gnt, imem2ifu_rvalid, imem2ifu_rdata, idu2ifu_stall,
               exu2ifu_branch_en, exu2ifu_jump_en, exu2ifu_target_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch PC, single-outstanding imem request FSM and 2-entry instruction queue; response pushed at
// its rvalid edge and presented the next cycle; decode stall holds the queue and throttles requests.
module ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RST_PC    = '0
) (
    input logic         clk,
    input logic         rst_n,
    ifu_fetch_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [CPU_WIDTH-1:0] PC_STEP    = CPU_WIDTH'(4);
    localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = ~CPU_WIDTH'(3);

    state_t               state;
    state_t               state_nxt;
    logic [CPU_WIDTH-1:0] fetch_pc;
    logic [CPU_WIDTH-1:0] req_pc;
    logic [1:0]           cnt;
    logic [1:0]           cnt_nxt;
    logic [CPU_WIDTH-1:0] hd_pc;
    logic [CPU_WIDTH-1:0] hd_inst;
    logic [CPU_WIDTH-1:0] tl_pc;
    logic [CPU_WIDTH-1:0] tl_inst;
    logic                 redirect;
    logic                 push;
    logic                 pop;
    logic                 req;
    logic                 grant;
    logic                 en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req is gated by rst_n so nothing is requested while the unit is held in reset.
    always_comb begin
        redirect  = bus.exu2ifu_branch_en | bus.exu2ifu_jump_en;
        push      = 1'b0;
        pop       = 1'b0;
        req       = 1'b0;
        grant     = 1'b0;
        en        = 1'b0;
        state_nxt = state;

        push    = (state == ST_WAIT) & bus.imem2ifu_rvalid;
        en      = (cnt != 2'd0) & ~bus.idu2ifu_stall & ~redirect;
        pop     = en;
        cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
        req     = rst_n & ~redirect
                & ((state == ST_IDLE) | ((state == ST_WAIT) & bus.imem2ifu_rvalid))
                & (cnt_nxt <= 2'd1);
        grant   = req & bus.imem2ifu_gnt;

        unique case (state)
            ST_IDLE: begin
                if (grant) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem2ifu_rvalid) begin
                    state_nxt = grant ? ST_WAIT : ST_IDLE;
                end else if (redirect) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.imem2ifu_rvalid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RST_PC;
            req_pc   <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= bus.exu2ifu_target_pc & ALIGN_MASK;
            end else if (grant) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (grant) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // Head register always holds the oldest entry; with cnt==1 a pop leaves it as the last-popped value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            hd_pc   <= '0;
            hd_inst <= '0;
            tl_pc   <= '0;
            tl_inst <= '0;
        end else if (redirect) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt_nxt;
            unique case ({push, pop})
                2'b11: begin
                    if (cnt == 2'd2) begin
                        hd_pc   <= tl_pc;
                        hd_inst <= tl_inst;
                        tl_pc   <= req_pc;
                        tl_inst <= bus.imem2ifu_rdata;
                    end else begin
                        hd_pc   <= req_pc;
                        hd_inst <= bus.imem2ifu_rdata;
                    end
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        hd_pc   <= req_pc;
                        hd_inst <= bus.imem2ifu_rdata;
                    end else begin
                        tl_pc   <= req_pc;
                        tl_inst <= bus.imem2ifu_rdata;
                    end
                end
                2'b01: begin
                    if (cnt == 2'd2) begin
                        hd_pc   <= tl_pc;
                        hd_inst <= tl_inst;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ifu2imem_req  = req;
    assign bus.ifu2imem_addr = fetch_pc;
    assign bus.ifu2idu_en    = en;
    assign bus.ifu2idu_pc    = hd_pc;
    assign bus.ifu2idu_inst  = hd_inst;
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an in-order latency-programmable instruction memory model.
module tb_ifu_fetch;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_if #(.CPU_WIDTH(32)) bus ();
    ifu_fetch #(.CPU_WIDTH(32), .RST_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int mem_lat    = 1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    int          got_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic take(input string tag, input logic [31:0] exp_pc, output int when);
        int n;
        n    = 0;
        when = -1;
        while (got_pc.size() == 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_avail"}, got_pc.size() != 0, 1);
        if (got_pc.size() != 0) begin
            chk({tag, "_pc"}, got_pc.pop_front(), exp_pc);
            chk({tag, "_inst"}, got_inst.pop_front(), exp_pc + 32'h100);
            when = got_cyc.pop_front();
        end
    endtask

    // Memory: word at address A holds A+'h100; response asserted mem_lat cycles after the grant cycle.
    initial begin : mem_model
        logic        g;
        logic [31:0] a;
        bus.imem2ifu_rvalid = 1'b0;
        bus.imem2ifu_rdata  = '0;
        forever begin
            @(negedge clk);
            g = bus.ifu2imem_req & bus.imem2ifu_gnt;
            a = bus.ifu2imem_addr;
            @(posedge clk);
            cyc++;
            #1;
            if (bus.imem2ifu_rvalid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (g) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc + mem_lat - 1);
            end
            bus.imem2ifu_rvalid = 1'b0;
            if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                bus.imem2ifu_rvalid = 1'b1;
                bus.imem2ifu_rdata  = pend_addr[0] + 32'h100;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.ifu2idu_en) begin
            got_pc.push_back(bus.ifu2idu_pc);
            got_inst.push_back(bus.ifu2idu_inst);
            got_cyc.push_back(cyc);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          rel;
        int          when;
        logic [31:0] exp;
        logic [31:0] a0;
        bit          found;

        bus.imem2ifu_gnt      = 1'b1;
        bus.idu2ifu_stall     = 1'b0;
        bus.exu2ifu_branch_en = 1'b0;
        bus.exu2ifu_jump_en   = 1'b0;
        bus.exu2ifu_target_pc = '0;

        // Reset values and first request
        step();
        step();
        @(negedge clk);
        chk("rst_req", bus.ifu2imem_req, 0);
        chk("rst_addr", bus.ifu2imem_addr, 32'h0);
        chk("rst_en", bus.ifu2idu_en, 0);
        chk("rst_pc", bus.ifu2idu_pc, 0);
        chk("rst_inst", bus.ifu2idu_inst, 0);
        step();
        rst_n = 1'b1;
        rel   = cyc;
        @(negedge clk);
        chk("first_req", bus.ifu2imem_req, 1);
        chk("first_addr", bus.ifu2imem_addr, 32'h0);

        // Back-to-back stream with 1-cycle memory
        exp = 32'h0;
        for (int k = 0; k < 8; k++) begin
            take("stream", exp, when);
            chk("stream_cyc", when, rel + 2 + k);
            exp += 32'd4;
        end

        // Decode stall: queue fills, requests stop, order preserved after release
        step();
        bus.idu2ifu_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("stall_en", bus.ifu2idu_en, 0);
            if (i >= 1) chk("stall_req", bus.ifu2imem_req, 0);
        end
        step();
        bus.idu2ifu_stall = 1'b0;
        @(negedge clk);
        chk("unstall_en", bus.ifu2idu_en, 1);
        for (int k = 0; k < 6; k++) begin
            take("unstall", exp, when);
            exp += 32'd4;
        end

        // Jump while a response is outstanding: stale response dropped
        mem_lat = 3;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (pend_addr.size() != 0 && !bus.imem2ifu_rvalid) found = 1'b1;
        end
        chk("jump_find", found, 1);
        bus.exu2ifu_jump_en   = 1'b1;
        bus.exu2ifu_target_pc = 32'h2003;
        got_pc.delete();
        got_inst.delete();
        got_cyc.delete();
        @(negedge clk);
        chk("jump_en", bus.ifu2idu_en, 0);
        chk("jump_req", bus.ifu2imem_req, 0);
        step();
        bus.exu2ifu_jump_en = 1'b0;
        take("jump_t0", 32'h2000, when);
        take("jump_t1", 32'h2004, when);

        // Branch+jump together with full queue and stall: flush, restart at target
        step();
        bus.idu2ifu_stall = 1'b1;
        for (int i = 0; i < 12; i++) step();
        bus.exu2ifu_branch_en = 1'b1;
        bus.exu2ifu_jump_en   = 1'b1;
        bus.exu2ifu_target_pc = 32'h300A;
        got_pc.delete();
        got_inst.delete();
        got_cyc.delete();
        @(negedge clk);
        chk("both_en", bus.ifu2idu_en, 0);
        chk("both_req", bus.ifu2imem_req, 0);
        step();
        bus.exu2ifu_branch_en = 1'b0;
        bus.exu2ifu_jump_en   = 1'b0;
        bus.idu2ifu_stall     = 1'b0;
        @(negedge clk);
        chk("flush_en", bus.ifu2idu_en, 0);
        chk("flush_req", bus.ifu2imem_req, 1);
        chk("flush_addr", bus.ifu2imem_addr, 32'h3008);
        take("both_t0", 32'h3008, when);
        take("both_t1", 32'h300C, when);
        exp = 32'h3010;

        // Grant withheld 2 cycles with 3-cycle memory: address held stable
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.ifu2imem_req) found = 1'b1;
        end
        chk("gnt_find", found, 1);
        bus.imem2ifu_gnt = 1'b0;
        @(negedge clk);
        a0 = bus.ifu2imem_addr;
        step();
        @(negedge clk);
        chk("nognt_req", bus.ifu2imem_req, 1);
        chk("nognt_addr", bus.ifu2imem_addr, a0);
        step();
        bus.imem2ifu_gnt = 1'b1;
        @(negedge clk);
        chk("gnt_req", bus.ifu2imem_req, 1);
        chk("gnt_addr", bus.ifu2imem_addr, a0);
        for (int k = 0; k < 5; k++) begin
            take("slow", exp, when);
            exp += 32'd4;
        end

        // Reset while a response is outstanding; it returns in the first cycle after release
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (pend_addr.size() != 0 && pend_due[0] == cyc + 1) found = 1'b1;
        end
        chk("rst2_find", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_req", bus.ifu2imem_req, 0);
        chk("rst2_addr", bus.ifu2imem_addr, 32'h0);
        chk("rst2_en", bus.ifu2idu_en, 0);
        chk("rst2_pc", bus.ifu2idu_pc, 0);
        step();
        rst_n = 1'b1;
        got_pc.delete();
        got_inst.delete();
        got_cyc.delete();
        chk("rst2_late_rvalid", bus.imem2ifu_rvalid, 1);
        take("rst2_t0", 32'h0, when);
        take("rst2_t1", 32'h4, when);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
